serial_frame_receiver: RTL and testbench
========================================

# serial_frame_receiver

Receive-side counterpart of the team's single-bit serial frame transmitter. Monitors a one-bit-per-clock serial line, hunts for the 8-bit start-of-frame delimiter (SFD), then deserialises a `data_len`-bit payload, LSB first. It presents the payload as a parallel word with a one-cycle valid strobe. It sits at the far end of the serial link, in the same clock domain as the transmitter.

## Interface
- `data_len`, 8, payload width in bits.
- `sfd_len_limit`, 8, SFD length in bits.
- `sfd`, 8'b11010101, delimiter value. Its bit 0 is sent first on the line.
- `clk`  input  1  system clock; all logic on posedge.
- `reset`  input  1  synchronous, active-high reset.
- `rx`  input  1  serial line. Synchronous to `clk`, one bit per cycle. Idle level is 0.
- `dout`  output  `data_len`  last received payload. Holds its value until the next frame completes.
- `rx_valid`  output  1  one-cycle pulse: `dout` has just been updated.
- `rx_busy`  output  1  high while a payload is being collected, after SFD lock.
- `frame_cnt`  output  16  count of completed frames. Wraps from 0xFFFF to 0.

## Operation
- Reset values: `dout`=0, `rx_valid`=0, `rx_busy`=0, `frame_cnt`=0, state HUNT, SFD window cleared to 0, bit counter 0.
- HUNT state:
  - Each cycle, `rx` shifts into the MSB of an `sfd_len_limit`-bit window; the window shifts right.
  - Lock occurs when the value just shifted in, combined with window[7:1], equals `sfd`. Because the window is LSB-first, this matches a transmitter that drives `sfd[0]` first.
  - On lock: go to DATA, counter <= 0, `rx_busy` <= 1.
  - Arbitrary bits before the SFD are tolerated because the window slides.
- DATA state:
  - Each cycle, `rx` shifts into the MSB of the payload shift register; counter increments.
  - On the cycle the counter equals `data_len`-1:
    - `dout` <= {rx, shreg[data_len-1:1]}.
    - `rx_valid` <= 1.
    - `frame_cnt` <= `frame_cnt`+1.
    - `rx_busy` <= 0.
    - SFD window cleared to 0.
    - Return to HUNT.
- Payload bits are never examined for SFD matches while in DATA. The window is cleared at frame end, so payload bits cannot combine with later bits into a false lock.
- `rx_valid` is 1 for exactly one cycle per frame and is 0 in every other cycle.
- There is no error or abort path. A broken frame is simply completed with whatever bits arrive.

## Timing
- Let t0 be the cycle in which `rx` carries SFD bit 0.
  - The edge ending cycle t0+7 locks; `rx_busy`=1 from cycle t0+8.
  - Payload bit j is on `rx` in cycle t0+8+j.
  - `dout` is updated and `rx_valid`=1 in cycle t0+8+`data_len`, i.e. one cycle after the last payload bit. This is t0+16 for defaults.
- Back-to-back frames: the receiver is back in HUNT on the cycle `rx_valid` is high, so an SFD starting in that cycle is detected. The transmitter's minimum one-cycle idle gap is therefore not required by the receiver.
- Reset asserted mid-SFD or mid-payload: the next cycle shows all outputs at reset values, with no `rx_valid`. `dout` and `frame_cnt` are also cleared.
- Reset wins over a simultaneous frame completion: no pulse, `frame_cnt` stays 0.
- `frame_cnt` wraps silently at 0xFFFF+1 = 0.

## Structure
- Shared package (shared with the transmitter):
  - SFD value 8'b11010101.
  - `sfd_len_limit`=8 and default `data_len`=8.
  - 1-bit state encoding: HUNT=0, DATA=1.
- Sub-module `sfd_detector`:
  - Contents: sliding window shift register, comparator, and clear input.
  - Outputs: a `lock` pulse.
- The top level holds the state machine, bit counter, payload shift register and output registers.

## Test plan
- Reset, then `rx`=0 for 100 cycles -> `rx_valid` never asserts; `dout`=0, `frame_cnt`=0, `rx_busy`=0.
- Three random bits, then SFD (1,0,1,0,1,0,1,1), then payload 0xA5 sent LSB first (1,0,1,0,0,1,0,1) -> `rx_busy` high for 8 cycles; `rx_valid` for one cycle, one cycle after the last payload bit; `dout`=0xA5; `frame_cnt`=1.
- Payload 0x3C, zero-gap SFD, then payload 0xC3 -> two `rx_valid` pulses 16 cycles apart; `dout`=0x3C then 0xC3; `frame_cnt`=2.
- Payload 0xD5 (equal to SFD), followed by 20 idle zeros -> exactly one `rx_valid` with `dout`=0xD5; no spurious second frame.
- Reset pulsed during payload bit 4, then a full frame with payload 0x81 -> no pulse for the aborted frame; then one pulse with `dout`=0x81 and `frame_cnt`=1.
- Seven SFD bits followed by 0, then idle -> no lock, `rx_busy` stays 0; force `frame_cnt` to 0xFFFF and send a valid frame -> `frame_cnt`=0.

Source files
------------

// File: rtl/serial_frame_receiver_pkg.sv
// Shared serial-link definitions: delimiter value, widths and receiver state encoding.
package serial_frame_receiver_pkg;

  localparam int SFD_LEN_LIMIT = 8;
  localparam int DEFAULT_DATA_LEN = 8;
  // Start-of-frame delimiter; bit 0 travels first on the line.
  localparam logic [SFD_LEN_LIMIT-1:0] SFD_VALUE = 8'b11010101;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } rx_state_t;

endpackage

// File: rtl/serial_frame_receiver_sfd_detector.sv
// Sliding LSB-first window over the serial line; pulses lock when the delimiter is seen.
module sfd_detector
  import serial_frame_receiver_pkg::*;
#(
  parameter int sfd_len_limit = SFD_LEN_LIMIT,
  parameter logic [sfd_len_limit-1:0] sfd = SFD_VALUE
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic clear,
  input  logic rx,
  output logic lock
);

  logic [sfd_len_limit-1:0] window_reg;
  logic [sfd_len_limit-1:0] window_next;

  // New bit enters at the MSB, older bits move toward the LSB.
  genvar gi;
  generate
    for (gi = 0; gi < sfd_len_limit - 1; gi++) begin : g_shift
      assign window_next[gi] = window_reg[gi+1];
    end
  endgenerate
  assign window_next[sfd_len_limit-1] = rx;

  // Compare against the window including the bit arriving this cycle.
  assign lock = shift_en && (window_next == sfd);

  // Window register: cleared at frame end so payload bits never contribute to a lock.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      window_reg <= '0;
    end else if (shift_en) begin
      window_reg <= window_next;
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: hunts for the delimiter, then collects an LSB-first payload.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int data_len = DEFAULT_DATA_LEN,
  parameter int sfd_len_limit = SFD_LEN_LIMIT,
  parameter logic [sfd_len_limit-1:0] sfd = SFD_VALUE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  output logic [data_len-1:0] dout,
  output logic                rx_valid,
  output logic                rx_busy,
  output logic [15:0]         frame_cnt
);

  localparam int CNT_W = (data_len > 1) ? $clog2(data_len) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(data_len - 1);

  rx_state_t           state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [data_len-1:0] shreg_reg, shreg_next;
  logic [data_len-1:0] dout_reg, dout_next;
  logic                valid_reg, valid_next;
  logic                busy_reg, busy_next;
  logic [15:0]         frame_cnt_reg, frame_cnt_next;
  logic                hunt_en;
  logic                win_clear;
  logic                lock;

  sfd_detector #(
    .sfd_len_limit(sfd_len_limit),
    .sfd          (sfd)
  ) u_sfd_detector (
    .clk     (clk),
    .reset   (reset),
    .shift_en(hunt_en),
    .clear   (win_clear),
    .rx      (rx),
    .lock    (lock)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath decisions: lock in HUNT, shift and finish frame in DATA.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    shreg_next     = shreg_reg;
    dout_next      = dout_reg;
    valid_next     = 1'b0;
    busy_next      = busy_reg;
    frame_cnt_next = frame_cnt_reg;
    hunt_en        = 1'b0;
    win_clear      = 1'b0;
    case (state_reg)
      HUNT: begin
        hunt_en = 1'b1;
        if (lock) begin
          state_next = DATA;
          cnt_next   = '0;
          busy_next  = 1'b1;
        end
      end
      DATA: begin
        shreg_next = {rx, shreg_reg[data_len-1:1]};
        cnt_next   = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_BIT) begin
          dout_next      = {rx, shreg_reg[data_len-1:1]};
          valid_next     = 1'b1;
          frame_cnt_next = frame_cnt_reg + 16'd1;
          busy_next      = 1'b0;
          win_clear      = 1'b1;
          state_next     = HUNT;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // Datapath and output registers; reset overrides any completing frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      shreg_reg     <= '0;
      dout_reg      <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      cnt_reg       <= cnt_next;
      shreg_reg     <= shreg_next;
      dout_reg      <= dout_next;
      valid_reg     <= valid_next;
      busy_reg      <= busy_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  assign dout      = dout_reg;
  assign rx_valid  = valid_reg;
  assign rx_busy   = busy_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: frame table plus hand-written corner sequences.
module tb_serial_frame_receiver;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] dout;
  logic       rx_valid;
  logic       rx_busy;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int busy_cycles = 0;
  logic [7:0] last_dout = 8'h00;

  localparam logic [7:0] SFD_BITS = 8'b11010101;

  serial_frame_receiver dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .dout     (dout),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         gap;
    int         pre_len;
    logic [7:0] pre_bits;
    logic [7:0] payload;
    logic [15:0] exp_cnt;
  } frame_vec_t;

  frame_vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one bit for one cycle, then observe the registered outputs mid-cycle.
  task automatic send_bit(input logic b);
    rx = b;
    @(negedge clk);
    if (rx_busy) busy_cycles++;
    if (rx_valid) begin
      pulses++;
      last_dout = dout;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic send_sfd();
    for (int i = 0; i < 8; i++) send_bit(SFD_BITS[i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  initial begin
    int p0, b0;
    vecs[0] = '{gap: 0, pre_len: 3, pre_bits: 8'b0000_0011, payload: 8'hA5, exp_cnt: 16'd1};
    vecs[1] = '{gap: 5, pre_len: 0, pre_bits: 8'h00,        payload: 8'h3C, exp_cnt: 16'd2};
    vecs[2] = '{gap: 0, pre_len: 0, pre_bits: 8'h00,        payload: 8'hC3, exp_cnt: 16'd3};
    vecs[3] = '{gap: 2, pre_len: 0, pre_bits: 8'h00,        payload: 8'hD5, exp_cnt: 16'd4};

    rx = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_valid", 32'(rx_valid), 32'h0);
    chk("reset_busy", 32'(rx_busy), 32'h0);
    chk("reset_cnt", 32'(frame_cnt), 32'h0);
    reset = 1'b0;

    // Long idle: nothing may lock on a quiet line.
    idle(100);
    chk("idle_pulses", 32'(pulses), 32'h0);
    chk("idle_busy", 32'(busy_cycles), 32'h0);
    chk("idle_dout", 32'(dout), 32'h0);
    chk("idle_cnt", 32'(frame_cnt), 32'h0);

    // Table of frames; gap 0 means the SFD starts in the cycle of the previous pulse.
    for (int v = 0; v < 4; v++) begin
      idle(vecs[v].gap);
      for (int i = 0; i < vecs[v].pre_len; i++) send_bit(vecs[v].pre_bits[i]);
      p0 = pulses;
      b0 = busy_cycles;
      send_sfd();
      send_byte(vecs[v].payload);
      $display("frame %0d payload=%02h dout=%02h valid=%0d cnt=%0d", v, vecs[v].payload, dout,
               rx_valid, frame_cnt);
      chk("frame_valid", 32'(rx_valid), 32'h1);
      chk("frame_dout", 32'(dout), 32'(vecs[v].payload));
      chk("frame_cnt", 32'(frame_cnt), 32'(vecs[v].exp_cnt));
      chk("frame_busy_len", 32'(busy_cycles - b0), 32'd8);
      chk("frame_pulse_once", 32'(pulses - p0), 32'd1);
    end

    // Payload equal to SFD followed by idle must not produce a second frame.
    p0 = pulses;
    idle(20);
    chk("no_false_lock", 32'(pulses - p0), 32'h0);
    chk("hold_dout", 32'(dout), 32'hD5);
    chk("hold_cnt", 32'(frame_cnt), 32'd4);

    // Reset during payload bit 4 aborts the frame and clears everything.
    p0 = pulses;
    send_sfd();
    send_byte_partial: for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1;
    send_bit(1'b1);
    reset = 1'b0;
    $display("reset mid-payload dout=%02h valid=%0d busy=%0d cnt=%0d", dout, rx_valid, rx_busy, frame_cnt);
    chk("abort_dout", 32'(dout), 32'h0);
    chk("abort_valid", 32'(rx_valid), 32'h0);
    chk("abort_busy", 32'(rx_busy), 32'h0);
    chk("abort_cnt", 32'(frame_cnt), 32'h0);
    idle(12);
    chk("abort_no_pulse", 32'(pulses - p0), 32'h0);
    send_sfd();
    send_byte(8'h81);
    $display("post-abort frame dout=%02h valid=%0d cnt=%0d", dout, rx_valid, frame_cnt);
    chk("after_abort_valid", 32'(rx_valid), 32'h1);
    chk("after_abort_dout", 32'(dout), 32'h81);
    chk("after_abort_cnt", 32'(frame_cnt), 32'h1);

    // Reset on the final payload bit beats frame completion.
    idle(3);
    p0 = pulses;
    send_sfd();
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    reset = 1'b1;
    send_bit(1'b1);
    reset = 1'b0;
    $display("reset at completion valid=%0d cnt=%0d", rx_valid, frame_cnt);
    chk("reset_wins_valid", 32'(rx_valid), 32'h0);
    chk("reset_wins_cnt", 32'(frame_cnt), 32'h0);
    idle(3);
    chk("reset_wins_pulses", 32'(pulses - p0), 32'h0);

    // Seven SFD bits then a zero: no lock.
    p0 = pulses;
    b0 = busy_cycles;
    for (int i = 0; i < 7; i++) send_bit(SFD_BITS[i]);
    send_bit(1'b0);
    idle(20);
    $display("partial sfd busy_cycles=%0d pulses=%0d", busy_cycles - b0, pulses - p0);
    chk("partial_sfd_busy", 32'(busy_cycles - b0), 32'h0);
    chk("partial_sfd_pulses", 32'(pulses - p0), 32'h0);

    // Frame counter wrap.
    force dut.frame_cnt_reg = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_reg;
    idle(2);
    send_sfd();
    send_byte(8'h5A);
    $display("wrap frame dout=%02h valid=%0d cnt=%04h", dout, rx_valid, frame_cnt);
    chk("wrap_valid", 32'(rx_valid), 32'h1);
    chk("wrap_dout", 32'(dout), 32'h5A);
    chk("wrap_cnt", 32'(frame_cnt), 32'h0);
    send_bit(1'b0);
    chk("pulse_one_cycle", 32'(rx_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
